// File: rtl/fuzzifier_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : fuzzifier_seq_if
// Description : Handshake and configuration bundle for fuzzifier_seq.
//               Carries the sample valid/ready pair, the table-write strobe
//               with its payload, and the result valid/ready pair with the
//               membership vector and active-set summary.
//               master : sample/config source and result sink
//               slave  : the fuzzifier itself
// Revision    : 1.0 - initial release
// ============================================================================
interface fuzzifier_seq_if #(
    parameter int DATA_W   = 8,
    parameter int MU_W     = 8,
    parameter int NUM_SETS = 11,
    parameter int IDX_W    = 4,
    parameter int SLOPE_W  = 12
);
    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_W-1:0]         crisp_in;
    logic                      cfg_we;
    logic [IDX_W-1:0]          cfg_idx;
    logic [DATA_W-1:0]         cfg_center;
    logic [SLOPE_W-1:0]        cfg_slope;
    logic                      busy;
    logic                      out_valid;
    logic                      out_ready;
    logic [NUM_SETS*MU_W-1:0]  mu_vec;
    logic [IDX_W-1:0]          active_cnt;
    logic [IDX_W-1:0]          first_idx;
    logic [IDX_W-1:0]          second_idx;

    modport master (
        output in_valid, crisp_in, cfg_we, cfg_idx, cfg_center, cfg_slope, out_ready,
        input  in_ready, busy, out_valid, mu_vec, active_cnt, first_idx, second_idx
    );

    modport slave (
        input  in_valid, crisp_in, cfg_we, cfg_idx, cfg_center, cfg_slope, out_ready,
        output in_ready, busy, out_valid, mu_vec, active_cnt, first_idx, second_idx
    );
endinterface
`default_nettype wire

// File: rtl/fuzzifier_seq.sv
`default_nettype none
// ============================================================================
// Module      : fuzzifier_seq
// Description : Table-driven sequential fuzzifier. Accepts one crisp sample,
//               evaluates NUM_SETS triangular membership functions one per
//               clock, then presents the membership vector, the number of
//               active sets and the two lowest active set indices.
//               Ports:
//                 clk  - system clock, rising edge
//                 rst  - synchronous active-high reset (reloads table)
//                 bus  - fuzzifier_seq_if.slave (sample in, config, result out)
// Revision    : 1.0 - initial release
// ============================================================================
module fuzzifier_seq #(
    parameter int DATA_W      = 8,
    parameter int MU_W        = 8,
    parameter int NUM_SETS    = 11,
    parameter int IDX_W       = 4,
    parameter int SLOPE_W     = 12,
    parameter int SLOPE_FRAC  = 4,
    parameter int CENTER_STEP = 10,
    parameter int DEF_SLOPE   = 408
) (
    input  wire logic      clk,
    input  wire logic      rst,
    fuzzifier_seq_if.slave bus
);
    localparam int              c_P_W      = DATA_W + 1 + SLOPE_W;
    localparam logic [MU_W-1:0]  c_MU_MAX   = '1;
    localparam logic [IDX_W-1:0] c_NONE     = '1;
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_SETS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    r_state;
    logic [DATA_W-1:0]         r_center [NUM_SETS];
    logic [SLOPE_W-1:0]        r_slope  [NUM_SETS];
    logic [DATA_W-1:0]         r_x;
    logic [IDX_W-1:0]          r_k;
    logic                      r_issue;
    // Second pipeline stage: the membership degree computed for set r_pk.
    logic                      r_pv;
    logic [IDX_W-1:0]          r_pk;
    logic [MU_W-1:0]           r_pmu;
    logic [NUM_SETS*MU_W-1:0]  r_mu_vec;
    logic [IDX_W-1:0]          r_cnt;
    logic [IDX_W-1:0]          r_first;
    logic [IDX_W-1:0]          r_second;
    logic                      r_in_ready;
    logic                      r_busy;
    logic                      r_out_valid;

    logic [DATA_W-1:0]         w_c;
    logic [SLOPE_W-1:0]        w_s;
    logic [DATA_W:0]           w_d;
    logic [c_P_W-1:0]          w_prod;
    logic [c_P_W-1:0]          w_p;
    logic                      w_sat;
    logic [MU_W-1:0]           w_mu;

    // Membership of the set currently addressed by r_k. The product is kept
    // at full width so large distances can never wrap back into range.
    always_comb begin
        w_c    = r_center[r_k];
        w_s    = r_slope[r_k];
        w_d    = (r_x >= w_c) ? ({1'b0, r_x} - {1'b0, w_c})
                              : ({1'b0, w_c} - {1'b0, r_x});
        w_prod = {{SLOPE_W{1'b0}}, w_d} * {{(DATA_W+1){1'b0}}, w_s};
        w_p    = w_prod >> SLOPE_FRAC;
        w_sat  = (w_p >= {{(c_P_W-MU_W){1'b0}}, c_MU_MAX});
        w_mu   = w_sat ? '0 : (c_MU_MAX - w_p[MU_W-1:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_x         <= '0;
            r_k         <= '0;
            r_issue     <= 1'b0;
            r_pv        <= 1'b0;
            r_pk        <= '0;
            r_pmu       <= '0;
            r_mu_vec    <= '0;
            r_cnt       <= '0;
            r_first     <= c_NONE;
            r_second    <= c_NONE;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            for (int i = 0; i < NUM_SETS; i++) begin
                r_center[i] <= DATA_W'(i * CENTER_STEP);
                r_slope[i]  <= SLOPE_W'(DEF_SLOPE);
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Table write lands at this edge, so a sample accepted in
                    // the same cycle already scans against the new entry.
                    if (bus.cfg_we && (bus.cfg_idx <= c_LAST_IDX)) begin
                        r_center[bus.cfg_idx] <= bus.cfg_center;
                        r_slope[bus.cfg_idx]  <= bus.cfg_slope;
                    end
                    if (bus.in_valid) begin
                        r_x        <= bus.crisp_in;
                        r_mu_vec   <= '0;
                        r_cnt      <= '0;
                        r_first    <= c_NONE;
                        r_second   <= c_NONE;
                        r_k        <= '0;
                        r_issue    <= 1'b1;
                        r_pv       <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_SCAN;
                    end
                end

                S_SCAN: begin
                    // Stage A: evaluate set r_k.
                    if (r_issue) begin
                        r_pmu <= w_mu;
                        r_pk  <= r_k;
                        r_pv  <= 1'b1;
                        if (r_k == c_LAST_IDX) begin
                            r_issue <= 1'b0;
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end else begin
                        r_pv <= 1'b0;
                    end

                    // Stage B: fold the evaluated degree into the result.
                    if (r_pv) begin
                        r_mu_vec[r_pk*MU_W +: MU_W] <= r_pmu;
                        if (r_pmu != '0) begin
                            if (r_cnt != c_NONE) begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                            if (r_first == c_NONE) begin
                                r_first <= r_pk;
                            end else if (r_second == c_NONE) begin
                                r_second <= r_pk;
                            end
                        end
                        if (r_pk == c_LAST_IDX) begin
                            r_pv        <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.busy       = r_busy;
    assign bus.out_valid  = r_out_valid;
    assign bus.mu_vec     = r_mu_vec;
    assign bus.active_cnt = r_cnt;
    assign bus.first_idx  = r_first;
    assign bus.second_idx = r_second;

endmodule
`default_nettype wire

// File: tb/tb_fuzzifier_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_fuzzifier_seq
// Description : Self-checking bench for fuzzifier_seq. Expected results come
//               from a behavioural membership model over a bench-side copy of
//               the set table and are queued at stimulus time.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fuzzifier_seq;
    localparam int DATA_W   = 8;
    localparam int MU_W     = 8;
    localparam int NUM_SETS = 11;
    localparam int IDX_W    = 4;
    localparam int SLOPE_W  = 12;
    localparam int LATENCY  = NUM_SETS + 1;

    typedef struct packed {
        logic [NUM_SETS*MU_W-1:0] mu;
        logic [IDX_W-1:0]         cnt;
        logic [IDX_W-1:0]         first;
        logic [IDX_W-1:0]         second;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fuzzifier_seq_if #(
        .DATA_W(DATA_W), .MU_W(MU_W), .NUM_SETS(NUM_SETS),
        .IDX_W(IDX_W), .SLOPE_W(SLOPE_W)
    ) bus ();

    fuzzifier_seq u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int   n_chk = 0;
    int   n_err = 0;
    int   m_c [NUM_SETS];
    int   m_s [NUM_SETS];
    exp_t q [$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_SETS; i++) begin
            m_c[i] = (i * 10) % 256;
            m_s[i] = 408;
        end
    endtask

    function automatic exp_t model(input int x);
        exp_t r;
        int   d, p, mu;
        r.mu     = '0;
        r.cnt    = '0;
        r.first  = 4'hF;
        r.second = 4'hF;
        for (int k = 0; k < NUM_SETS; k++) begin
            d  = (x > m_c[k]) ? (x - m_c[k]) : (m_c[k] - x);
            p  = (d * m_s[k]) / 16;
            mu = (p >= 255) ? 0 : (255 - p);
            r.mu[k*MU_W +: MU_W] = mu[7:0];
            if (mu != 0) begin
                if (r.cnt != 4'hF) r.cnt = r.cnt + 1'b1;
                if (r.first == 4'hF) r.first = k[3:0];
                else if (r.second == 4'hF) r.second = k[3:0];
            end
        end
        return r;
    endfunction

    task automatic cfg_write(input int idx, input int c, input int s, input bit applies);
        @(negedge clk);
        bus.cfg_we     = 1'b1;
        bus.cfg_idx    = idx[IDX_W-1:0];
        bus.cfg_center = c[DATA_W-1:0];
        bus.cfg_slope  = s[SLOPE_W-1:0];
        @(posedge clk);
        #1 bus.cfg_we = 1'b0;
        if (applies && idx < NUM_SETS) begin
            m_c[idx] = c;
            m_s[idx] = s;
        end
    endtask

    // One complete transaction: optional same-cycle table write, handshake,
    // latency measurement, result comparison, optional hold in DONE with an
    // attempted (ignored) table write, then release.
    task automatic run(input string tag, input int x, input bit wr, input int widx,
                       input int wc, input int ws, input int hold);
        exp_t e;
        int   n;
        bit   got;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) chk({tag, "_idle_timeout"}, 0, 1);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.crisp_in = x[DATA_W-1:0];
        if (wr) begin
            bus.cfg_we     = 1'b1;
            bus.cfg_idx    = widx[IDX_W-1:0];
            bus.cfg_center = wc[DATA_W-1:0];
            bus.cfg_slope  = ws[SLOPE_W-1:0];
            if (widx < NUM_SETS) begin
                m_c[widx] = wc;
                m_s[widx] = ws;
            end
        end
        q.push_back(model(x));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.cfg_we   = 1'b0;
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.out_valid) got = 1'b1;
        end
        if (!got) begin
            chk({tag, "_out_valid_timeout"}, 0, 1);
            void'(q.pop_front());
            return;
        end
        chk({tag, "_latency"}, n, LATENCY);
        e = q.pop_front();
        chk({tag, "_mu_vec"}, bus.mu_vec, e.mu);
        chk({tag, "_active_cnt"}, bus.active_cnt, e.cnt);
        chk({tag, "_first_idx"}, bus.first_idx, e.first);
        chk({tag, "_second_idx"}, bus.second_idx, e.second);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (h == 0) begin
                bus.cfg_we     = 1'b1;
                bus.cfg_idx    = '0;
                bus.cfg_center = 8'd200;
                bus.cfg_slope  = 12'd408;
            end else begin
                bus.cfg_we = 1'b0;
            end
            chk({tag, "_hold_valid"}, bus.out_valid, 1);
            chk({tag, "_hold_in_ready"}, bus.in_ready, 0);
            chk({tag, "_hold_mu_vec"}, bus.mu_vec, e.mu);
        end
        @(negedge clk);
        bus.cfg_we    = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        chk({tag, "_release_valid"}, bus.out_valid, 0);
        chk({tag, "_release_in_ready"}, bus.in_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.crisp_in   = '0;
        bus.cfg_we     = 1'b0;
        bus.cfg_idx    = '0;
        bus.cfg_center = '0;
        bus.cfg_slope  = '0;
        bus.out_ready  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_mu_vec", bus.mu_vec, 0);
        chk("rst_active_cnt", bus.active_cnt, 0);
        chk("rst_first_idx", bus.first_idx, 4'hF);
        chk("rst_second_idx", bus.second_idx, 4'hF);
        @(negedge clk);
        rst = 1'b0;

        run("x15", 15, 0, 0, 0, 0, 0);
        run("x0", 0, 0, 0, 0, 0, 0);
        run("x200", 200, 0, 0, 0, 0, 0);
        run("x255", 255, 0, 0, 0, 0, 0);

        cfg_write(3, 33, 0, 1'b1);
        run("flat3_x100", 100, 0, 0, 0, 0, 0);

        // Write attempted while held in DONE must not reach set 0.
        run("hold_x0", 0, 0, 0, 0, 0, 20);
        run("after_hold_x0", 0, 0, 0, 0, 0, 0);

        cfg_write(12, 5, 0, 1'b1);
        run("badidx_x15", 15, 0, 0, 0, 0, 0);

        run("samecyc_x15", 15, 1, 5, 15, 408, 0);

        // Reset in the middle of a scan.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.crisp_in = 8'd15;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        chk("midscan_busy", bus.busy, 1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midscan_rst_out_valid", bus.out_valid, 0);
        chk("midscan_rst_in_ready", bus.in_ready, 1);
        chk("midscan_rst_busy", bus.busy, 0);
        chk("midscan_rst_mu_vec", bus.mu_vec, 0);
        chk("midscan_rst_first", bus.first_idx, 4'hF);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        q.delete();
        run("post_rst_x15", 15, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fuzzifier_seq.md
Name: fuzzifier_seq

Overview:
Parametrised, table-driven successor to the fixed 11-set frequency fuzzifier. It accepts one crisp sample over a valid/ready handshake and scans NUM_SETS triangular membership functions, one per clock. It then presents the full membership vector plus the two lowest active set indices to the rule-evaluation stage. Set centres and slopes are held in a runtime-writable table, reloaded with evenly spaced defaults on reset.

Parameters:
DATA_W, 8, crisp input and set-centre width
MU_W, 8, membership degree width; MU_MAX = 2^MU_W-1
NUM_SETS, 11, number of fuzzy sets (2..15)
IDX_W, 4, set index width; the all-ones value means "none"
SLOPE_W, 12, slope table entry width
SLOPE_FRAC, 4, fractional bits of slope
CENTER_STEP, 10, reset centre spacing; centre_i = i*CENTER_STEP, truncated to DATA_W
DEF_SLOPE, 408, reset slope for every set

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  crisp sample valid
in_ready  out  1  high only in IDLE
crisp_in  in  DATA_W  crisp sample, unsigned
cfg_we  in  1  table write strobe
cfg_idx  in  IDX_W  table entry to write
cfg_center  in  DATA_W  new centre
cfg_slope  in  SLOPE_W  new slope
busy  out  1  high in SCAN or DONE
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
mu_vec  out  NUM_SETS*MU_W  degree of set i at bits [i*MU_W +: MU_W]
active_cnt  out  IDX_W  number of sets with mu != 0
first_idx  out  IDX_W  lowest active index, or all-ones
second_idx  out  IDX_W  second-lowest active index, or all-ones

Behaviour:
- Reset, on any cycle including mid-scan:
  - state=IDLE; in_ready=1; busy=0; out_valid=0.
  - mu_vec=0; active_cnt=0; first_idx=second_idx=all-ones.
  - Table reloaded with defaults; any in-flight sample is discarded.
- FSM:
  - IDLE -> SCAN when in_valid&&in_ready. crisp_in is latched, mu_vec/active_cnt are cleared, first/second are set to all-ones, and the set counter k=0.
  - SCAN: one set per cycle, k=0..NUM_SETS-1. After k=NUM_SETS-1 the next state is DONE.
  - DONE: out_valid=1 and all outputs are held stable. On out_ready the FSM returns to IDLE and out_valid drops the next cycle. A new sample can be accepted no earlier than the cycle after that.
- Latency: handshake at edge T; out_valid is high from edge T+NUM_SETS+1 (T+12 at defaults).
- Membership of set k:
  - d = |x - c_k|, computed unsigned in DATA_W+1 bits.
  - p = (d*s_k) >> SLOPE_FRAC, full-width product with no truncation before the compare.
  - mu = 0 if p >= MU_MAX; otherwise mu = MU_MAX - p.
  - Slope 0 gives mu = MU_MAX for every x.
- Active tracking during SCAN, when mu != 0:
  - active_cnt increments, saturating at all-ones.
  - If first_idx is all-ones it takes k; else if second_idx is all-ones it takes k.
- Config writes:
  - Applied in the cycle after cfg_we, only while in IDLE. Ignored (no effect) in SCAN or DONE.
  - Ignored when cfg_idx >= NUM_SETS.
  - Write and in_valid in the same IDLE cycle: the write commits first, so the sample uses the new entry.
- Boundaries:
  - x=0 and x=2^DATA_W-1 are legal.
  - Centre at the range edge produces a half-triangle (no wrap).
  - No set active gives count 0 with both indices all-ones.
  - With exactly one active set, second_idx stays all-ones.

Test Plan:
- Defaults, crisp_in=15 -> mu[1]=128, mu[2]=128, all others 0; active_cnt=2, first_idx=1, second_idx=2; out_valid exactly 12 cycles after handshake.
- Defaults, crisp_in=0 -> mu[0]=255, mu[1]=0 (d=10, p=255); active_cnt=1, first_idx=0, second_idx=4'hF.
- Defaults, crisp_in=200 -> mu_vec=0, active_cnt=0, first_idx=second_idx=4'hF.
- Write idx 3 with centre 33 and slope 0, then crisp_in=100 -> mu[3]=255, mu[10]=255; first_idx=3, second_idx=10, active_cnt=2.
- Hold out_ready=0 for 20 cycles in DONE -> outputs and out_valid stable, in_ready=0; a cfg write to idx 0 is ignored, confirmed by crisp_in=0 still giving mu[0]=255. A write with cfg_idx=12 in IDLE also has no effect.
- Assert rst at scan cycle 5 -> next cycle: IDLE, out_valid=0, mu_vec=0, table at defaults; a subsequent crisp_in=15 gives the first scenario's result.
